// File: rtl/dma_desc_pkg.sv
// Shared definitions for the DMA descriptor mux/demux pair: default field widths,
// port-index width and flattened-bus field offset helpers.
package dma_desc_pkg;

  localparam int DEF_PORTS        = 4;
  localparam int DEF_PCIE_ADDR_W  = 64;
  localparam int DEF_S_RAM_SEL_W  = 1;
  localparam int DEF_RAM_ADDR_W   = 16;
  localparam int DEF_LEN_W        = 16;
  localparam int DEF_S_TAG_W      = 8;

  function automatic int port_idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int fld_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/dma_desc_mux_if.sv
// Client-side descriptor/status streams and DMA-IF-side descriptor/status streams of dma_desc_mux.
interface dma_desc_mux_if #(
  parameter int PORTS           = dma_desc_pkg::DEF_PORTS,
  parameter int PCIE_ADDR_WIDTH = dma_desc_pkg::DEF_PCIE_ADDR_W,
  parameter int S_RAM_SEL_WIDTH = dma_desc_pkg::DEF_S_RAM_SEL_W,
  parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + dma_desc_pkg::port_idx_w(PORTS),
  parameter int RAM_ADDR_WIDTH  = dma_desc_pkg::DEF_RAM_ADDR_W,
  parameter int LEN_WIDTH       = dma_desc_pkg::DEF_LEN_W,
  parameter int S_TAG_WIDTH     = dma_desc_pkg::DEF_S_TAG_W,
  parameter int M_TAG_WIDTH     = S_TAG_WIDTH + dma_desc_pkg::port_idx_w(PORTS)
);
  logic [PORTS*PCIE_ADDR_WIDTH-1:0] s_axis_desc_pcie_addr;
  logic [PORTS*S_RAM_SEL_WIDTH-1:0] s_axis_desc_ram_sel;
  logic [PORTS*RAM_ADDR_WIDTH-1:0]  s_axis_desc_ram_addr;
  logic [PORTS*LEN_WIDTH-1:0]       s_axis_desc_len;
  logic [PORTS*S_TAG_WIDTH-1:0]     s_axis_desc_tag;
  logic [PORTS-1:0]                 s_axis_desc_valid;
  logic [PORTS-1:0]                 s_axis_desc_ready;
  logic [PCIE_ADDR_WIDTH-1:0]       m_axis_desc_pcie_addr;
  logic [M_RAM_SEL_WIDTH-1:0]       m_axis_desc_ram_sel;
  logic [RAM_ADDR_WIDTH-1:0]        m_axis_desc_ram_addr;
  logic [LEN_WIDTH-1:0]             m_axis_desc_len;
  logic [M_TAG_WIDTH-1:0]           m_axis_desc_tag;
  logic                             m_axis_desc_valid;
  logic                             m_axis_desc_ready;
  logic [M_TAG_WIDTH-1:0]           s_axis_desc_status_tag;
  logic                             s_axis_desc_status_valid;
  logic [PORTS*S_TAG_WIDTH-1:0]     m_axis_desc_status_tag;
  logic [PORTS-1:0]                 m_axis_desc_status_valid;
  logic                             status_error_port;

  modport master (
    input  s_axis_desc_pcie_addr, s_axis_desc_ram_sel, s_axis_desc_ram_addr,
           s_axis_desc_len, s_axis_desc_tag, s_axis_desc_valid,
    output s_axis_desc_ready,
    output m_axis_desc_pcie_addr, m_axis_desc_ram_sel, m_axis_desc_ram_addr,
           m_axis_desc_len, m_axis_desc_tag, m_axis_desc_valid,
    input  m_axis_desc_ready,
    input  s_axis_desc_status_tag, s_axis_desc_status_valid,
    output m_axis_desc_status_tag, m_axis_desc_status_valid, status_error_port
  );

  modport slave (
    output s_axis_desc_pcie_addr, s_axis_desc_ram_sel, s_axis_desc_ram_addr,
           s_axis_desc_len, s_axis_desc_tag, s_axis_desc_valid,
    input  s_axis_desc_ready,
    input  m_axis_desc_pcie_addr, m_axis_desc_ram_sel, m_axis_desc_ram_addr,
           m_axis_desc_len, m_axis_desc_tag, m_axis_desc_valid,
    output m_axis_desc_ready,
    output s_axis_desc_status_tag, s_axis_desc_status_valid,
    input  m_axis_desc_status_tag, m_axis_desc_status_valid, status_error_port
  );
endinterface

// File: rtl/dma_desc_mux_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer; the pointer moves past
// the winner only when the grant is actually accepted.
module dma_rr_arbiter import dma_desc_pkg::*; #(
  parameter int PORTS        = DEF_PORTS,
  parameter bit ARB_LSB_HIGH = 1'b1,
  localparam int IW          = port_idx_w(PORTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] i_req,
  input  logic             i_ack,
  output logic [PORTS-1:0] o_grant,
  output logic [IW-1:0]    o_idx
);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] PTR_RST = ARB_LSB_HIGH ? '0 : IW'(PORTS - 1);

  logic [IW-1:0] r_ptr;
  logic [CW-1:0] w_cand;
  logic [CW-1:0] w_nxt;
  logic          w_found;

  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < PORTS; k++) begin
      w_cand = {1'b0, r_ptr} + CW'(k);
      if (w_cand >= CW'(PORTS)) w_cand = w_cand - CW'(PORTS);
      if (!w_found && i_req[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        o_idx   = w_cand[IW-1:0];
      end
    end
    o_grant = w_found ? (PORTS'(1) << o_idx) : '0;
  end

  always_comb begin
    w_nxt = {1'b0, o_idx} + CW'(1);
    if (w_nxt >= CW'(PORTS)) w_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     r_ptr <= PTR_RST;
    else if (i_ack) r_ptr <= w_nxt[IW-1:0];
  end
endmodule

// File: rtl/dma_desc_mux.sv
// Multiplexes PORTS client descriptor streams onto one DMA IF descriptor input, tagging each
// descriptor with its source port, and steers returned status back to that port.
module dma_desc_mux import dma_desc_pkg::*; #(
  parameter int PORTS           = DEF_PORTS,
  parameter int PCIE_ADDR_WIDTH = DEF_PCIE_ADDR_W,
  parameter int S_RAM_SEL_WIDTH = DEF_S_RAM_SEL_W,
  parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + port_idx_w(PORTS),
  parameter int RAM_ADDR_WIDTH  = DEF_RAM_ADDR_W,
  parameter int LEN_WIDTH       = DEF_LEN_W,
  parameter int S_TAG_WIDTH     = DEF_S_TAG_W,
  parameter int M_TAG_WIDTH     = S_TAG_WIDTH + port_idx_w(PORTS),
  parameter bit ARB_LSB_HIGH    = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  dma_desc_mux_if.master bus
);
  localparam int IW = port_idx_w(PORTS);
  localparam int CW = IW + 1;
  localparam int DW = PCIE_ADDR_WIDTH + M_RAM_SEL_WIDTH + RAM_ADDR_WIDTH + LEN_WIDTH + M_TAG_WIDTH;

  logic [PORTS-1:0]       w_grant;
  logic [PORTS-1:0]       w_ready;
  logic [IW-1:0]          w_idx;
  logic                   w_acc;
  logic                   w_out_free;
  logic [DW-1:0]          w_desc;
  logic [IW-1:0]          w_st_idx;
  logic                   w_st_ok;
  logic                   r_run;
  logic [DW-1:0]          r_out_p1;
  logic                   r_out_vld_p1;
  logic [DW-1:0]          r_skid_p1;
  logic                   r_skid_vld_p1;
  logic [S_TAG_WIDTH-1:0] r_st_tag_p1;
  logic [PORTS-1:0]       r_st_vld_p1;
  logic                   r_st_err_p1;

  dma_rr_arbiter #(.PORTS(PORTS), .ARB_LSB_HIGH(ARB_LSB_HIGH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (bus.s_axis_desc_valid),
    .i_ack   (w_acc),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // r_run keeps ready low through reset and the first cycle after it
  assign w_ready    = w_grant & {PORTS{r_run & ~r_skid_vld_p1}};
  assign w_acc      = |(bus.s_axis_desc_valid & w_ready);
  assign w_out_free = ~r_out_vld_p1 | bus.m_axis_desc_ready;
  assign bus.s_axis_desc_ready = w_ready;

  always_comb begin
    w_desc = {bus.s_axis_desc_pcie_addr[fld_lsb(int'(w_idx), PCIE_ADDR_WIDTH) +: PCIE_ADDR_WIDTH],
              w_idx,
              bus.s_axis_desc_ram_sel[fld_lsb(int'(w_idx), S_RAM_SEL_WIDTH) +: S_RAM_SEL_WIDTH],
              bus.s_axis_desc_ram_addr[fld_lsb(int'(w_idx), RAM_ADDR_WIDTH) +: RAM_ADDR_WIDTH],
              bus.s_axis_desc_len[fld_lsb(int'(w_idx), LEN_WIDTH) +: LEN_WIDTH],
              w_idx,
              bus.s_axis_desc_tag[fld_lsb(int'(w_idx), S_TAG_WIDTH) +: S_TAG_WIDTH]};
  end

  assign w_st_idx = bus.s_axis_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];
  assign w_st_ok  = {1'b0, w_st_idx} < CW'(PORTS);

  // stage p1: output register + skid (control)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_out_vld_p1  <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_st_vld_p1   <= '0;
      r_st_err_p1   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_out_free) begin
        if (r_skid_vld_p1) begin
          r_out_vld_p1  <= 1'b1;
          r_skid_vld_p1 <= 1'b0;
        end else begin
          r_out_vld_p1  <= w_acc;
        end
      end else if (w_acc) begin
        r_skid_vld_p1 <= 1'b1;
      end
      r_st_vld_p1 <= '0;
      r_st_err_p1 <= 1'b0;
      if (bus.s_axis_desc_status_valid) begin
        if (w_st_ok) r_st_vld_p1 <= PORTS'(1) << w_st_idx;
        else         r_st_err_p1 <= 1'b1;
      end
    end
  end

  // stage p1: output register + skid (data)
  always_ff @(posedge clk) begin
    if (w_out_free) begin
      if (r_skid_vld_p1) r_out_p1 <= r_skid_p1;
      else if (w_acc)    r_out_p1 <= w_desc;
    end else if (w_acc) begin
      r_skid_p1 <= w_desc;
    end
    if (bus.s_axis_desc_status_valid) r_st_tag_p1 <= bus.s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
  end

  assign {bus.m_axis_desc_pcie_addr, bus.m_axis_desc_ram_sel, bus.m_axis_desc_ram_addr,
          bus.m_axis_desc_len, bus.m_axis_desc_tag} = r_out_p1;
  assign bus.m_axis_desc_valid        = r_out_vld_p1;
  assign bus.m_axis_desc_status_tag   = {PORTS{r_st_tag_p1}};
  assign bus.m_axis_desc_status_valid = r_st_vld_p1;
  assign bus.status_error_port        = r_st_err_p1;
endmodule

// File: tb/tb_dma_desc_mux.sv
// Directed and randomized checks of dma_desc_mux: a 4-port instance for the descriptor and status
// paths, and a 3-port instance for out-of-range status indices.
module tb_dma_desc_mux;
  logic clk = 1'b0;
  logic rst_n;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dma_desc_mux_if #(.PORTS(4)) b4 ();
  dma_desc_mux_if #(.PORTS(3)) b3 ();

  dma_desc_mux #(.PORTS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.master));
  dma_desc_mux #(.PORTS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.master));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_addr(input int p, input logic [31:0] seq);
    return {32'(p) + 32'h1000, seq};
  endfunction

  task automatic set_port(input int p, input logic [31:0] seq);
    b4.s_axis_desc_tag[p*8 +: 8]        = seq[7:0];
    b4.s_axis_desc_ram_sel[p]           = p[0];
    b4.s_axis_desc_pcie_addr[p*64 +: 64] = exp_addr(p, seq);
    b4.s_axis_desc_ram_addr[p*16 +: 16] = {8'(p), seq[7:0]};
    b4.s_axis_desc_len[p*16 +: 16]      = {seq[7:0], 8'(p)};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seq [4];
    int          q   [4][$];
    logic [9:0]  mt;
    int          mp;
    int          e;
    logic        pv;
    logic [1:0]  pidx;
    logic [7:0]  ptag;
    logic [9:0]  st;
    logic [3:0]  sv;

    // Reset with every client requesting
    rst_n = 1'b0;
    b4.s_axis_desc_valid = 4'hF;
    b4.m_axis_desc_ready = 1'b1;
    b4.s_axis_desc_status_tag = '0;
    b4.s_axis_desc_status_valid = 1'b0;
    b3.s_axis_desc_pcie_addr = '0; b3.s_axis_desc_ram_sel = '0; b3.s_axis_desc_ram_addr = '0;
    b3.s_axis_desc_len = '0; b3.s_axis_desc_tag = '0; b3.s_axis_desc_valid = '0;
    b3.m_axis_desc_ready = 1'b1;
    b3.s_axis_desc_status_tag = '0;
    b3.s_axis_desc_status_valid = 1'b0;
    set_port(0, 32'h11); set_port(1, 32'h22); set_port(2, 32'h5A); set_port(3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_m_valid", 64'(b4.m_axis_desc_valid), 64'd0);
      chk("rst_s_ready", 64'(b4.s_axis_desc_ready), 64'd0);
      chk("rst_st_valid", 64'(b4.m_axis_desc_status_valid), 64'd0);
      chk("rst_err", 64'(b4.status_error_port), 64'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_m_valid", 64'(b4.m_axis_desc_valid), 64'd0);
    chk("first_grant", 64'(b4.s_axis_desc_ready), 64'h1);

    // Round-robin order 0,1,2,3,0 at full throughput
    for (int k = 0; k < 5; k++) begin
      int p;
      logic [7:0] t;
      p = k % 4;
      t = (p == 0) ? 8'h11 : (p == 1) ? 8'h22 : (p == 2) ? 8'h5A : 8'h33;
      tick();
      chk("rr_valid", 64'(b4.m_axis_desc_valid), 64'd1);
      chk("rr_tag", 64'(b4.m_axis_desc_tag), 64'((p << 8) | t));
      chk("rr_addr", b4.m_axis_desc_pcie_addr, exp_addr(p, 32'(t)));
      if (p == 2) chk("rr_ram_sel_p2", 64'(b4.m_axis_desc_ram_sel), 64'b100);
    end
    b4.s_axis_desc_valid = 4'h0;
    tick();
    chk("drain_valid", 64'(b4.m_axis_desc_valid), 64'd0);

    // Stall: port 1 streams while m_ready is low for 5 cycles
    b4.m_axis_desc_ready = 1'b0;
    b4.s_axis_desc_valid = 4'b0010;
    set_port(1, 32'h61);
    #1;
    chk("stall_ready0", 64'(b4.s_axis_desc_ready), 64'b0010);
    tick();
    chk("stall_out_valid", 64'(b4.m_axis_desc_valid), 64'd1);
    chk("stall_out_tag", 64'(b4.m_axis_desc_tag), 64'h161);
    chk("stall_ready1", 64'(b4.s_axis_desc_ready), 64'b0010);
    set_port(1, 32'h62);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_ready_off", 64'(b4.s_axis_desc_ready), 64'd0);
      chk("stall_tag_hold", 64'(b4.m_axis_desc_tag), 64'h161);
      chk("stall_addr_hold", b4.m_axis_desc_pcie_addr, exp_addr(1, 32'h61));
      set_port(1, 32'h63);
    end
    b4.m_axis_desc_ready = 1'b1;
    tick();
    chk("skid_out_valid", 64'(b4.m_axis_desc_valid), 64'd1);
    chk("skid_out_tag", 64'(b4.m_axis_desc_tag), 64'h162);
    chk("skid_ready_back", 64'(b4.s_axis_desc_ready), 64'b0010);
    b4.s_axis_desc_valid = 4'h0;
    tick();
    chk("skid_no_dup", 64'(b4.m_axis_desc_valid), 64'd0);

    // Status routing and out-of-range index
    b4.s_axis_desc_status_tag = 10'h3A7; b4.s_axis_desc_status_valid = 1'b1;
    b3.s_axis_desc_status_tag = 10'h3A7; b3.s_axis_desc_status_valid = 1'b1;
    tick();
    chk("st4_valid", 64'(b4.m_axis_desc_status_valid), 64'b1000);
    chk("st4_tag", 64'(b4.m_axis_desc_status_tag[31:24]), 64'hA7);
    chk("st4_err", 64'(b4.status_error_port), 64'd0);
    chk("st3_err", 64'(b3.status_error_port), 64'd1);
    chk("st3_valid", 64'(b3.m_axis_desc_status_valid), 64'd0);
    b4.s_axis_desc_status_tag = 10'h112;
    b3.s_axis_desc_status_tag = 10'h2B4;
    tick();
    chk("st4_valid_p1", 64'(b4.m_axis_desc_status_valid), 64'b0010);
    chk("st4_tag_p1", 64'(b4.m_axis_desc_status_tag[15:8]), 64'h12);
    chk("st3_valid_p2", 64'(b3.m_axis_desc_status_valid), 64'b100);
    chk("st3_tag_p2", 64'(b3.m_axis_desc_status_tag[23:16]), 64'hB4);
    chk("st3_err_clr", 64'(b3.status_error_port), 64'd0);
    b4.s_axis_desc_status_valid = 1'b0;
    b3.s_axis_desc_status_valid = 1'b0;
    tick();
    chk("st4_pulse_end", 64'(b4.m_axis_desc_status_valid), 64'd0);

    // Reset during a stall with output and skid both full
    b4.m_axis_desc_ready = 1'b0;
    b4.s_axis_desc_valid = 4'b0100;
    set_port(2, 32'h44);
    tick();
    chk("rs_out_tag", 64'(b4.m_axis_desc_tag), 64'h244);
    tick();
    chk("rs_full_ready", 64'(b4.s_axis_desc_ready), 64'd0);
    rst_n = 1'b0;
    b4.s_axis_desc_valid = 4'hF;
    tick();
    chk("rs_valid_clr", 64'(b4.m_axis_desc_valid), 64'd0);
    chk("rs_ready_clr", 64'(b4.s_axis_desc_ready), 64'd0);
    rst_n = 1'b1;
    b4.m_axis_desc_ready = 1'b1;
    tick();
    chk("rs_ptr_reset", 64'(b4.s_axis_desc_ready), 64'h1);
    b4.s_axis_desc_valid = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_no_stale", 64'(b4.m_axis_desc_valid), 64'd0);
    end

    // Randomized traffic with per-port ordering scoreboard and status routing
    for (int p = 0; p < 4; p++) seq[p] = p * 4096;
    pv = 1'b0; pidx = '0; ptag = '0;
    for (int c = 0; c < 3200; c++) begin
      logic drain;
      drain = (c >= 3000);
      sv = pv ? (4'(1) << pidx) : 4'd0;
      chk("rnd_st_valid", 64'(b4.m_axis_desc_status_valid), 64'(sv));
      if (pv) chk("rnd_st_tag", 64'(b4.m_axis_desc_status_tag[pidx*8 +: 8]), 64'(ptag));
      for (int p = 0; p < 4; p++) begin
        set_port(p, 32'(seq[p]));
        b4.s_axis_desc_valid[p] = !drain && ($urandom_range(0, 99) < 55);
      end
      b4.m_axis_desc_ready = drain || ($urandom_range(0, 99) < 70);
      st = 10'($urandom);
      pv = !drain && ($urandom_range(0, 3) == 0);
      pidx = st[9:8]; ptag = st[7:0];
      b4.s_axis_desc_status_tag = st;
      b4.s_axis_desc_status_valid = pv;
      #1;
      chk("rnd_ready_onehot0", 64'($onehot0(b4.s_axis_desc_ready)), 64'd1);
      if (b4.m_axis_desc_valid && b4.m_axis_desc_ready) begin
        mt = b4.m_axis_desc_tag;
        mp = int'(mt[9:8]);
        if (q[mp].size() == 0) begin
          chk("rnd_unexpected_desc", 64'(mt), 64'h3FF_FFFF);
        end else begin
          e = q[mp].pop_front();
          chk("rnd_tag", 64'(mt), 64'((mp << 8) | (e & 255)));
          chk("rnd_addr", b4.m_axis_desc_pcie_addr, exp_addr(mp, 32'(e)));
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (b4.s_axis_desc_valid[p] && b4.s_axis_desc_ready[p]) begin
          q[p].push_back(seq[p]);
          seq[p]++;
        end
      end
      tick();
    end
    for (int p = 0; p < 4; p++) chk("rnd_queue_empty", 64'(q[p].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
